// File: rtl/if_branch_prediction_gshare_if.sv
// rtl/if_branch_prediction_gshare_if.sv - lookup/feedback bundle between IF/EX and the gshare predictor (BHT_TARGET_EN adds target fields)
interface if_branch_prediction_gshare_if #(
    parameter int HIST_BITS = 8
);
    logic [31:0]          pc_jmp;
    logic                 pc_predict_fire;
    logic                 pc_prediction_take;
    logic [HIST_BITS-1:0] pc_prediction_hist;
    logic                 pc_jmp_feedback;
    logic [31:0]          pc_stash_base;
    logic                 pc_jmp_take;
    logic [HIST_BITS-1:0] pc_feedback_hist;
    logic                 pc_feedback_mispredict;
    logic                 bht_ready;
`ifdef BHT_TARGET_EN
    logic [31:0]          pc_feedback_target;
    logic [31:0]          pc_prediction_target;
    logic                 pc_prediction_target_valid;
`endif

    modport master (
        output pc_jmp, pc_predict_fire, pc_jmp_feedback, pc_stash_base,
               pc_jmp_take, pc_feedback_hist, pc_feedback_mispredict,
`ifdef BHT_TARGET_EN
        output pc_feedback_target,
        input  pc_prediction_target, pc_prediction_target_valid,
`endif
        input  pc_prediction_take, pc_prediction_hist, bht_ready
    );

    modport slave (
        input  pc_jmp, pc_predict_fire, pc_jmp_feedback, pc_stash_base,
               pc_jmp_take, pc_feedback_hist, pc_feedback_mispredict,
`ifdef BHT_TARGET_EN
        input  pc_feedback_target,
        output pc_prediction_target, pc_prediction_target_valid,
`endif
        output pc_prediction_take, pc_prediction_hist, bht_ready
    );
endinterface

// File: rtl/if_branch_prediction_gshare.sv
// rtl/if_branch_prediction_gshare.sv - tagged gshare direction predictor with repairable GHR and init sweep (BHT_TARGET_EN adds targets)
module if_branch_prediction_gshare #(
    parameter int INDEX_BITS   = 10,
    parameter int CNT_BITS     = 2,
    parameter int HIST_BITS    = 8,
    parameter int PC_LSB       = 0,
    parameter bit DEFAULT_TAKE = 1'b1
) (
    input  logic clk,
    input  logic reset,
    if_branch_prediction_gshare_if.slave bus
);
    localparam int DEPTH    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - PC_LSB - INDEX_BITS;
    localparam logic [CNT_BITS-1:0] WEAK_T = CNT_BITS'(1 << (CNT_BITS - 1));
    localparam logic [CNT_BITS-1:0] WEAK_N = WEAK_T - 1'b1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                state, state_nxt;
    logic [INDEX_BITS-1:0] init_ptr;
    logic [HIST_BITS-1:0]  ghr;

    // Table arrays carry no reset; the sweep clears valid so they stay RAM-friendly.
    logic                  valid_mem [DEPTH];
    logic [TAG_BITS-1:0]   tag_mem   [DEPTH];
    logic [CNT_BITS-1:0]   cnt_mem   [DEPTH];
`ifdef BHT_TARGET_EN
    logic [31:0]           target_mem [DEPTH];
`endif

    logic [INDEX_BITS-1:0] lidx, uidx;
    logic [TAG_BITS-1:0]   ltag, utag;
    logic                  lhit, uhit, run, upd;
    logic [CNT_BITS-1:0]   ucnt, cnt_nxt;

    assign run  = (state == S_RUN);
    assign upd  = run && bus.pc_jmp_feedback;
    assign lidx = bus.pc_jmp[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(ghr);
    assign ltag = bus.pc_jmp[31 -: TAG_BITS];
    assign uidx = bus.pc_stash_base[PC_LSB +: INDEX_BITS] ^ INDEX_BITS'(bus.pc_feedback_hist);
    assign utag = bus.pc_stash_base[31 -: TAG_BITS];
    assign lhit = run && valid_mem[lidx] && (tag_mem[lidx] == ltag);
    assign uhit = valid_mem[uidx] && (tag_mem[uidx] == utag);
    assign ucnt = cnt_mem[uidx];

    assign bus.pc_prediction_take = lhit ? cnt_mem[lidx][CNT_BITS-1] : DEFAULT_TAKE;
    assign bus.pc_prediction_hist = ghr;
    assign bus.bht_ready          = run;
`ifdef BHT_TARGET_EN
    assign bus.pc_prediction_target       = target_mem[lidx];
    assign bus.pc_prediction_target_valid = lhit;
`endif

    always_comb begin
        cnt_nxt = ucnt;
        if (!uhit)
            cnt_nxt = bus.pc_jmp_take ? WEAK_T : WEAK_N;
        else if (bus.pc_jmp_take && (ucnt != {CNT_BITS{1'b1}}))
            cnt_nxt = ucnt + 1'b1;
        else if (!bus.pc_jmp_take && (ucnt != '0))
            cnt_nxt = ucnt - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && (&init_ptr))
            state_nxt = S_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            init_ptr <= '0;
        else if (state == S_INIT)
            init_ptr <= init_ptr + 1'b1;
    end

    // Repair wins over fire: a branch fired alongside a mispredict is wrong-path.
    // The width cast drops the oldest bit, which also covers HIST_BITS == 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ghr <= '0;
        else if (run) begin
            if (bus.pc_jmp_feedback && bus.pc_feedback_mispredict)
                ghr <= HIST_BITS'({bus.pc_feedback_hist, bus.pc_jmp_take});
            else if (bus.pc_predict_fire)
                ghr <= HIST_BITS'({ghr, bus.pc_prediction_take});
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_INIT)
            valid_mem[init_ptr] <= 1'b0;
        else if (upd) begin
            valid_mem[uidx] <= 1'b1;
            tag_mem[uidx]   <= utag;
            cnt_mem[uidx]   <= cnt_nxt;
`ifdef BHT_TARGET_EN
            target_mem[uidx] <= bus.pc_feedback_target;
`endif
        end
    end
endmodule

// File: tb/tb_if_branch_prediction_gshare.sv
// tb/tb_if_branch_prediction_gshare.sv - directed self-checking bench for the gshare predictor
module tb_if_branch_prediction_gshare;
    localparam int HB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    if_branch_prediction_gshare_if #(.HIST_BITS(HB)) bus ();

    if_branch_prediction_gshare #(
        .INDEX_BITS(4), .CNT_BITS(2), .HIST_BITS(HB), .PC_LSB(0), .DEFAULT_TAKE(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic feedback(input logic [31:0] pc, input logic take, input logic [HB-1:0] hist,
                            input logic misp, input logic fire);
        bus.pc_stash_base          = pc;
        bus.pc_jmp_take            = take;
        bus.pc_feedback_hist       = hist;
        bus.pc_feedback_mispredict = misp;
        bus.pc_predict_fire        = fire;
        bus.pc_jmp_feedback        = 1'b1;
        @(posedge clk); #1;
        bus.pc_jmp_feedback        = 1'b0;
        bus.pc_feedback_mispredict = 1'b0;
        bus.pc_predict_fire        = 1'b0;
    endtask

    task automatic fire_once();
        bus.pc_predict_fire = 1'b1;
        @(posedge clk); #1;
        bus.pc_predict_fire = 1'b0;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic exp);
        bus.pc_jmp = pc;
        #1;
        check(tag, 32'(bus.pc_prediction_take), 32'(exp));
    endtask

    initial begin
        bus.pc_jmp = 32'h40;
        bus.pc_predict_fire = 1'b0;
        bus.pc_jmp_feedback = 1'b0;
        bus.pc_stash_base = '0;
        bus.pc_jmp_take = 1'b0;
        bus.pc_feedback_hist = '0;
        bus.pc_feedback_mispredict = 1'b0;
`ifdef BHT_TARGET_EN
        bus.pc_feedback_target = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", 32'(bus.bht_ready), 32'd0);
        check("reset_hist", 32'(bus.pc_prediction_hist), 32'd0);
        check("reset_take", 32'(bus.pc_prediction_take), 32'd1);

        // Sweep of 16 entries; feedback/fire issued mid-sweep must be ignored.
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("init_ready", 32'(bus.bht_ready), 32'd0);
            check("init_take", 32'(bus.pc_prediction_take), 32'd1);
            if (i == 3) begin
                bus.pc_stash_base = 32'h40;
                bus.pc_jmp_take = 1'b0;
                bus.pc_feedback_hist = 4'hF;
                bus.pc_feedback_mispredict = 1'b1;
                bus.pc_predict_fire = 1'b1;
                bus.pc_jmp_feedback = 1'b1;
            end
            @(posedge clk); #1;
            bus.pc_jmp_feedback = 1'b0;
            bus.pc_feedback_mispredict = 1'b0;
            bus.pc_predict_fire = 1'b0;
        end
        check("run_ready", 32'(bus.bht_ready), 32'd1);
        check("run_hist", 32'(bus.pc_prediction_hist), 32'd0);
        lookup("run_take_0x40", 32'h40, 1'b1);

        feedback(32'h123, 1'b0, 4'h0, 1'b0, 1'b0);
        lookup("nt1_cnt01", 32'h123, 1'b0);
        feedback(32'h123, 1'b0, 4'h0, 1'b0, 1'b0);
        lookup("nt2_cnt00", 32'h123, 1'b0);
        feedback(32'h123, 1'b0, 4'h0, 1'b0, 1'b0);
        lookup("nt3_sat00", 32'h123, 1'b0);

        feedback(32'h123, 1'b1, 4'h0, 1'b0, 1'b0);
        lookup("t1_cnt01", 32'h123, 1'b0);
        feedback(32'h123, 1'b1, 4'h0, 1'b0, 1'b0);
        lookup("t2_cnt10", 32'h123, 1'b1);
        feedback(32'h123, 1'b1, 4'h0, 1'b0, 1'b0);
        lookup("t3_cnt11", 32'h123, 1'b1);
        feedback(32'h123, 1'b1, 4'h0, 1'b0, 1'b0);
        lookup("t4_sat11", 32'h123, 1'b1);
        feedback(32'h123, 1'b0, 4'h0, 1'b0, 1'b0);
        lookup("nt_from11", 32'h123, 1'b1);

        feedback(32'h133, 1'b0, 4'h0, 1'b0, 1'b0);
        lookup("alias_old_miss", 32'h123, 1'b1);
        lookup("alias_new_hit", 32'h133, 1'b0);

        lookup("fire1_pred", 32'h40, 1'b1);
        fire_once();
        check("fire1_ghr", 32'(bus.pc_prediction_hist), 32'h1);
        lookup("fire2_pred", 32'h132, 1'b0);
        fire_once();
        check("fire2_ghr", 32'(bus.pc_prediction_hist), 32'h2);
        lookup("fire3_pred", 32'h40, 1'b1);
        fire_once();
        check("fire3_ghr", 32'(bus.pc_prediction_hist), 32'h5);
        feedback(32'h77, 1'b0, 4'h1, 1'b1, 1'b1);
        check("repair_ghr", 32'(bus.pc_prediction_hist), 32'h2);

        lookup("pre_rst_0x131", 32'h131, 1'b0);
        lookup("pre_rst_0x74", 32'h74, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_ready", 32'(bus.bht_ready), 32'd0);
        check("rst_hist", 32'(bus.pc_prediction_hist), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("resweep_ready", 32'(bus.bht_ready), 32'd0);
            @(posedge clk); #1;
        end
        check("resweep_done", 32'(bus.bht_ready), 32'd1);
        lookup("post_rst_0x133", 32'h133, 1'b1);
        lookup("post_rst_0x76", 32'h76, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_branch_prediction_gshare.md
Name: if_branch_prediction_gshare

Overview:
Parametrised successor to the IF-stage BHT. It is a tagged gshare direction predictor with N-bit saturating counters and a speculative global history register (GHR) that is repaired on mispredict. An init sweep invalidates the table after reset, so the table arrays need no reset and remain RAM-inferable. It sits beside the IF PC mux: lookup on pc_jmp, update on EX feedback against pc_stash_base.

Parameters:
INDEX_BITS, 10, table depth = 2^INDEX_BITS entries
CNT_BITS, 2, saturating counter width (>=1)
HIST_BITS, 8, GHR width (1..INDEX_BITS)
PC_LSB, 0, lowest PC bit used for index (0 keeps legacy indexing, 2 skips byte offset)
DEFAULT_TAKE, 1, prediction returned on table miss or during init

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
pc_jmp  in  32  lookup PC (branch being fetched)
pc_predict_fire  in  1  IF consumed this cycle's prediction for a branch; shift GHR
pc_prediction_take  out  1  predicted direction (combinational from pc_jmp, GHR, table)
pc_prediction_hist  out  HIST_BITS  GHR value used for this lookup, carried down the pipe
pc_jmp_feedback  in  1  EX resolved a branch this cycle
pc_stash_base  in  32  PC of resolved branch
pc_jmp_take  in  1  resolved direction
pc_feedback_hist  in  HIST_BITS  pc_prediction_hist captured at that branch's lookup
pc_feedback_mispredict  in  1  resolved direction differed from prediction
bht_ready  out  1  init sweep done; table live

Behaviour:
- Index = pc[PC_LSB+INDEX_BITS-1:PC_LSB] XOR zero-extended history. Lookup uses the GHR; update uses pc_feedback_hist. Tag = pc[31:PC_LSB+INDEX_BITS].
- Per entry: valid, tag, counter. Predict take = counter MSB.
- Lookup: hit (valid && tag match) -> counter MSB; miss -> DEFAULT_TAKE. Purely combinational, zero latency. pc_prediction_hist = GHR.
- FSM INIT/RUN. Reset -> INIT, init_ptr=0, GHR=0, bht_ready=0.
  - INIT: clear valid[init_ptr] each cycle, init_ptr++. After clearing entry 2^INDEX_BITS-1 -> RUN.
  - bht_ready=1 from the first RUN cycle, exactly 2^INDEX_BITS cycles after reset deasserts.
- During INIT: feedback and fire are ignored, GHR holds 0, prediction = DEFAULT_TAKE.
- Reset mid-INIT or mid-RUN restarts the sweep from 0.
- Update on posedge when RUN && pc_jmp_feedback:
  - hit: counter saturating +1 if taken, -1 if not taken.
  - miss or invalid: write valid=1, new tag, counter = 2^(CNT_BITS-1) if taken (weak take), else 2^(CNT_BITS-1)-1 (weak not-take).
- GHR (RUN only):
  - pc_jmp_feedback && pc_feedback_mispredict -> GHR <= {pc_feedback_hist[HIST_BITS-2:0], pc_jmp_take}.
  - else pc_predict_fire -> GHR <= {GHR[HIST_BITS-2:0], pc_prediction_take}.
  - Repair beats fire in the same cycle (the fired branch is wrong-path).
  - HIST_BITS=1: shift degenerates to a direct load.
- Same-cycle write and lookup to the same index: lookup returns the pre-write value (no bypass).
- Counter at max and taken stays max; at 0 and not-taken stays 0.

Optional Feature:
BHT_TARGET_EN. When defined:
- Each entry additionally stores a 32-bit target.
- Extra inputs: pc_feedback_target (32), written on every RUN update.
- Extra outputs: pc_prediction_target (32) and pc_prediction_target_valid (1, = lookup hit), both combinational.
- The target is overwritten even on a not-taken update.

When undefined: no target storage, and the extra ports are absent.

Test Plan:
1. Reset, INDEX_BITS=4 -> bht_ready low 16 cycles then high; pc_jmp=0x40 during and after init -> take=1 (DEFAULT_TAKE), hist=0.
2. GHR=0, feedback pc_stash_base=0x123, take=0, hist=0 -> next lookup pc_jmp=0x123 gives take=0 (counter 01). Repeat not-take -> counter 00, stays 00 on a third.
3. Entry at 0x123 counter 00, feed take=1 twice -> counter 10, prediction 1. Two more takes -> counter 11 saturates.
4. Alias: entry 0x123 valid, feedback 0x523 (same index, different tag, INDEX_BITS=10) take=0 -> tag replaced. Lookup 0x123 now misses -> take=1.
5. Fire 3 times with predictions 1,0,1 -> GHR=0x05. Then mispredict feedback hist=0x01, take=0 with fire asserted the same cycle -> GHR=0x02.
6. Assert reset for one cycle mid-RUN after training -> bht_ready drops, GHR=0, and after the re-sweep all prior entries miss.
